// File: rtl/tnoc_pkg.sv
// Shared definitions for the tiny-NoC router output stage.
package tnoc_pkg;

    // Input port order of the router; the enum values double as port indices.
    typedef enum logic [2:0] {
        PORT_XP = 3'd0,
        PORT_XM = 3'd1,
        PORT_YP = 3'd2,
        PORT_YM = 3'd3,
        PORT_L  = 3'd4
    } tnoc_port_type;

    // Wormhole lock state of one virtual channel.
    typedef enum logic {
        VC_FREE   = 1'b0,
        VC_LOCKED = 1'b1
    } tnoc_lock_e;

    // Counter width able to hold 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Index of the set bit of a one-hot vector (0 when empty).
    function automatic int onehot_to_index(input logic [31:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/tnoc_round_robin_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner only when the caller commits the grant.
module tnoc_round_robin_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] request,
    input  logic         i_update,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    // Search requesters starting from the pointer, wrapping around.
    always_comb begin
        grant = '0;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N;
            if (!found && request[idx]) begin
                grant[idx] = 1'b1;
                win        = PW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Pointer moves to winner+1 on a committed grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (i_update && found) begin
            ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
    end

endmodule

// File: rtl/tnoc_output_arbiter.sv
// Router output-port stage: per-VC wormhole locking with input round-robin,
// VC round-robin per link cycle, credit flow control and a registered link.
module tnoc_output_arbiter
    import tnoc_pkg::*;
#(
    parameter int PORTS        = 5,
    parameter int CHANNELS     = 2,
    parameter int FLIT_WIDTH   = 64,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [PORTS-1:0]                     i_valid,
    input  logic [PORTS-1:0][CHANNELS-1:0]       i_vc,
    input  logic [PORTS-1:0]                     i_head,
    input  logic [PORTS-1:0]                     i_tail,
    input  logic [PORTS-1:0][FLIT_WIDTH-1:0]     i_data,
    output logic [PORTS-1:0]                     o_ready,
    output logic                                 o_valid,
    output logic [CHANNELS-1:0]                  o_vc,
    output logic                                 o_head,
    output logic                                 o_tail,
    output logic [FLIT_WIDTH-1:0]                o_data,
    input  logic [CHANNELS-1:0]                  i_credit_return
);
    localparam int            CW       = credit_width(BUFFER_DEPTH);
    localparam int            PW       = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(BUFFER_DEPTH);

    tnoc_lock_e [CHANNELS-1:0]              lock_st, lock_nxt;
    logic       [CHANNELS-1:0][PW-1:0]      lock_owner, owner_nxt;
    logic       [CHANNELS-1:0][CW-1:0]      credits;
    logic       [CHANNELS-1:0][PORTS-1:0]   head_req, in_gnt, sel;
    logic       [CHANNELS-1:0]              vc_req, vc_gnt, in_upd;
    logic       [CHANNELS-1:0]              credit_ovf, proto_err;
    logic                                   xfer;
    logic       [PW-1:0]                    win_port;
    logic                                   win_head, win_tail;
    logic       [FLIT_WIDTH-1:0]            win_data;

    // Per-VC candidate selection: head requests when free, the owner when locked.
    always_comb begin
        head_req  = '0;
        sel       = '0;
        vc_req    = '0;
        proto_err = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int p = 0; p < PORTS; p++) begin
                head_req[c][p] = i_valid[p] & i_vc[p][c] & i_head[p];
                if (lock_st[c] == VC_LOCKED && p != int'(lock_owner[c]) &&
                    i_valid[p] && i_vc[p][c] && !i_head[p])
                    proto_err[c] = 1'b1;
            end
            if (lock_st[c] == VC_LOCKED)
                sel[c][lock_owner[c]] = i_valid[lock_owner[c]] & i_vc[lock_owner[c]][c];
            else
                sel[c] = in_gnt[c];
            // Nothing may be accepted while reset is held.
            vc_req[c] = rst_n & (|sel[c]) & (credits[c] != '0);
        end
    end

    // One input arbiter per VC for head flits.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_in_arb
        tnoc_round_robin_arbiter #(.N(PORTS)) u_arb (
            .clk      (clk),
            .rst_n    (rst_n),
            .request  (head_req[c]),
            .i_update (in_upd[c]),
            .grant    (in_gnt[c])
        );
    end

    // Link-level arbiter between eligible VCs.
    tnoc_round_robin_arbiter #(.N(CHANNELS)) u_vc_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .request  (vc_req),
        .i_update (xfer),
        .grant    (vc_gnt)
    );

    // Handshake, winning flit mux and lock next-state.
    always_comb begin
        o_ready    = '0;
        in_upd     = '0;
        credit_ovf = '0;
        lock_nxt   = lock_st;
        owner_nxt  = lock_owner;
        for (int c = 0; c < CHANNELS; c++) begin
            if (vc_gnt[c]) o_ready = o_ready | sel[c];
        end
        xfer     = |o_ready;
        win_port = PW'(onehot_to_index(32'(o_ready)));
        win_head = i_head[win_port];
        win_tail = i_tail[win_port];
        win_data = i_data[win_port];
        for (int c = 0; c < CHANNELS; c++) begin
            // Input pointer only moves when a head wins a free VC.
            in_upd[c] = vc_gnt[c] & (lock_st[c] == VC_FREE);
            // A return with no send while full would overflow: flagged and dropped.
            credit_ovf[c] = i_credit_return[c] & ~vc_gnt[c] & (credits[c] == CRED_MAX);
            if (vc_gnt[c]) begin
                if (lock_st[c] == VC_FREE && win_head && !win_tail) begin
                    lock_nxt[c]  = VC_LOCKED;
                    owner_nxt[c] = win_port;
                end else if (lock_st[c] == VC_LOCKED && win_tail) begin
                    lock_nxt[c]  = VC_FREE;
                end
            end
        end
    end

    // Lock state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_st    <= {CHANNELS{VC_FREE}};
            lock_owner <= '0;
        end else begin
            lock_st    <= lock_nxt;
            lock_owner <= owner_nxt;
        end
    end

    // Credit counters: send decrements, return increments, both cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) credits[c] <= CRED_MAX;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (vc_gnt[c] && !i_credit_return[c])
                    credits[c] <= credits[c] - CW'(1);
                else if (i_credit_return[c] && !vc_gnt[c] && !credit_ovf[c])
                    credits[c] <= credits[c] + CW'(1);
            end
        end
    end

    // Registered link output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_vc    <= '0;
            o_head  <= 1'b0;
            o_tail  <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= xfer;
            o_vc    <= vc_gnt;
            if (xfer) begin
                o_head <= win_head;
                o_tail <= win_tail;
                o_data <= win_data;
            end
        end
    end

    // A locked VC must only see body/tail flits from its owner.
    assert property (@(posedge clk) disable iff (!rst_n) proto_err == '0)
        else $error("tnoc_output_arbiter: non-owner body flit on locked VC");

endmodule

// File: tb/tb_tnoc_output_arbiter.sv
module tb_tnoc_output_arbiter;
    import tnoc_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic [4:0]            i_valid, i_head, i_tail;
    logic [4:0][1:0]       i_vc;
    logic [4:0][63:0]      i_data;
    logic [4:0]            o_ready;
    logic                  o_valid, o_head, o_tail;
    logic [1:0]            o_vc;
    logic [63:0]           o_data;
    logic [1:0]            i_credit_return;

    typedef struct packed {
        logic [1:0]  vc;
        logic        head;
        logic        tail;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   vecs  = 0;
    int   fails = 0;

    tnoc_output_arbiter #(.PORTS(5), .CHANNELS(2), .FLIT_WIDTH(64), .BUFFER_DEPTH(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_valid         (i_valid),
        .i_vc            (i_vc),
        .i_head          (i_head),
        .i_tail          (i_tail),
        .i_data          (i_data),
        .o_ready         (o_ready),
        .o_valid         (o_valid),
        .o_vc            (o_vc),
        .o_head          (o_head),
        .o_tail          (o_tail),
        .o_data          (o_data),
        .i_credit_return (i_credit_return)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_flit(input int p, input int c, input logic h, input logic t, input logic [63:0] d);
        i_valid[p] = 1'b1;
        i_vc[p]    = 2'(1 << c);
        i_head[p]  = h;
        i_tail[p]  = t;
        i_data[p]  = d;
    endtask

    task automatic clr(input int p);
        i_valid[p] = 1'b0;
        i_vc[p]    = '0;
        i_head[p]  = 1'b0;
        i_tail[p]  = 1'b0;
    endtask

    // One link cycle: check o_ready mid-cycle, queue the flits expected to be
    // accepted, then check the registered link just after the edge.
    task automatic cycle(input logic [4:0] exp_rdy);
        exp_t e;
        @(negedge clk);
        chk("o_ready", 64'(o_ready), 64'(exp_rdy));
        for (int p = 0; p < 5; p++) begin
            if (exp_rdy[p]) begin
                e.vc = i_vc[p]; e.head = i_head[p]; e.tail = i_tail[p]; e.data = i_data[p];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("o_valid", 64'(o_valid), 64'd1);
            chk("o_vc",    64'(o_vc),    64'(e.vc));
            chk("o_head",  64'(o_head),  64'(e.head));
            chk("o_tail",  64'(o_tail),  64'(e.tail));
            chk("o_data",  o_data,       e.data);
        end else begin
            chk("o_valid_idle", 64'(o_valid), 64'd0);
        end
    endtask

    task automatic ret(input logic [1:0] m, input int n);
        i_credit_return = m;
        repeat (n) cycle(5'b00000);
        i_credit_return = '0;
    endtask

    initial begin
        int n1, n3, p;
        rst_n = 1'b0;
        i_valid = '0; i_head = '0; i_tail = '0; i_vc = '0; i_data = '0;
        i_credit_return = '0;
        // Valid head during reset must not be accepted.
        set_flit(int'(PORT_XP), 0, 1'b1, 1'b1, 64'h99);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_vc",    64'(o_vc),    64'd0);
        chk("rst_o_head",  64'(o_head),  64'd0);
        chk("rst_o_tail",  64'(o_tail),  64'd0);
        chk("rst_o_data",  o_data,       64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd0);
        chk("rst_cred0",   64'(dut.credits[0]), 64'd8);
        chk("rst_cred1",   64'(dut.credits[1]), 64'd8);
        chk("rst_lock0",   64'(dut.lock_st[0]), 64'(VC_FREE));
        chk("rst_ptr0",    64'(dut.g_in_arb[0].u_arb.ptr), 64'd0);
        clr(int'(PORT_XP));
        rst_n = 1'b1;
        cycle(5'b00000);

        // 1: input 4 sends head/body/tail on VC0.
        set_flit(int'(PORT_L), 0, 1'b1, 1'b0, 64'h41);
        cycle(5'b10000);
        chk("t1_lock_owner", 64'(dut.lock_owner[0]), 64'd4);
        set_flit(int'(PORT_L), 0, 1'b0, 1'b0, 64'h42);
        cycle(5'b10000);
        set_flit(int'(PORT_L), 0, 1'b0, 1'b1, 64'h43);
        cycle(5'b10000);
        clr(int'(PORT_L));
        cycle(5'b00000);
        chk("t1_cred0", 64'(dut.credits[0]), 64'd5);
        chk("t1_lock0", 64'(dut.lock_st[0]), 64'(VC_FREE));
        chk("t1_ptr0",  64'(dut.g_in_arb[0].u_arb.ptr), 64'd0);
        ret(2'b01, 3);
        chk("t1_cred0_back", 64'(dut.credits[0]), 64'd8);

        // 2: inputs 0 and 2 contend for VC0 with 2-flit packets.
        set_flit(int'(PORT_XP), 0, 1'b1, 1'b0, 64'h01);
        set_flit(int'(PORT_YP), 0, 1'b1, 1'b0, 64'h21);
        cycle(5'b00001);
        chk("t2_ptr0_after_p0", 64'(dut.g_in_arb[0].u_arb.ptr), 64'd1);
        chk("t2_lock0", 64'(dut.lock_st[0]), 64'(VC_LOCKED));
        set_flit(int'(PORT_XP), 0, 1'b0, 1'b1, 64'h02);
        cycle(5'b00001);
        clr(int'(PORT_XP));
        cycle(5'b00100);
        chk("t2_ptr0_after_p2", 64'(dut.g_in_arb[0].u_arb.ptr), 64'd3);
        set_flit(int'(PORT_YP), 0, 1'b0, 1'b1, 64'h22);
        cycle(5'b00100);
        clr(int'(PORT_YP));
        cycle(5'b00000);
        chk("t2_cred0", 64'(dut.credits[0]), 64'd4);
        ret(2'b01, 4);

        // 3: inputs 1 (VC0) and 3 (VC1) stream 4-flit packets; VC pointer
        //    sits at 1 after the VC0 traffic so VC1 goes first.
        n1 = 0; n3 = 0;
        set_flit(int'(PORT_XM), 0, 1'b1, 1'b0, 64'h11);
        set_flit(int'(PORT_YM), 1, 1'b1, 1'b0, 64'h31);
        for (int k = 0; k < 8; k++) begin
            p = (k % 2 == 0) ? 3 : 1;
            cycle(5'(1 << p));
            if (p == 1) begin
                n1++;
                if (n1 == 4) clr(1);
                else set_flit(1, 0, 1'b0, n1 == 3, 64'h11 + 64'(n1));
            end else begin
                n3++;
                if (n3 == 4) clr(3);
                else set_flit(3, 1, 1'b0, n3 == 3, 64'h31 + 64'(n3));
            end
        end
        cycle(5'b00000);
        chk("t3_cred0", 64'(dut.credits[0]), 64'd4);
        chk("t3_cred1", 64'(dut.credits[1]), 64'd4);
        ret(2'b11, 4);

        // 4: exhaust VC1 credits with single-flit packets.
        for (int i = 0; i < 8; i++) begin
            set_flit(int'(PORT_L), 1, 1'b1, 1'b1, 64'h400 + 64'(i));
            cycle(5'b10000);
        end
        set_flit(int'(PORT_L), 1, 1'b1, 1'b1, 64'h408);
        cycle(5'b00000);
        cycle(5'b00000);
        chk("t4_cred1_empty", 64'(dut.credits[1]), 64'd0);
        i_credit_return = 2'b10;
        cycle(5'b00000);
        i_credit_return = 2'b00;
        cycle(5'b10000);
        clr(int'(PORT_L));
        chk("t4_cred1_after", 64'(dut.credits[1]), 64'd0);
        ret(2'b10, 8);
        chk("t4_cred1_back", 64'(dut.credits[1]), 64'd8);

        // 5: simultaneous send/return, then return while full.
        for (int i = 0; i < 5; i++) begin
            set_flit(int'(PORT_XP), 0, 1'b1, 1'b1, 64'h500 + 64'(i));
            cycle(5'b00001);
        end
        chk("t5_cred0_3", 64'(dut.credits[0]), 64'd3);
        set_flit(int'(PORT_XP), 0, 1'b1, 1'b1, 64'h505);
        i_credit_return = 2'b01;
        cycle(5'b00001);
        i_credit_return = 2'b00;
        clr(int'(PORT_XP));
        chk("t5_cred0_same", 64'(dut.credits[0]), 64'd3);
        ret(2'b01, 5);
        chk("t5_cred0_full", 64'(dut.credits[0]), 64'd8);
        i_credit_return = 2'b01;
        #1;
        chk("t5_ovf_flag", 64'(dut.credit_ovf[0]), 64'd1);
        cycle(5'b00000);
        chk("t5_cred0_held", 64'(dut.credits[0]), 64'd8);
        i_credit_return = 2'b00;
        #1;
        chk("t5_ovf_clear", 64'(dut.credit_ovf[0]), 64'd0);

        // 6: reset mid-packet with VC0 locked to input 2.
        set_flit(int'(PORT_YP), 0, 1'b1, 1'b0, 64'h601);
        cycle(5'b00100);
        set_flit(int'(PORT_YP), 0, 1'b0, 1'b0, 64'h602);
        cycle(5'b00100);
        set_flit(int'(PORT_YP), 0, 1'b0, 1'b0, 64'h603);
        cycle(5'b00100);
        chk("t6_lock0",  64'(dut.lock_st[0]), 64'(VC_LOCKED));
        chk("t6_owner0", 64'(dut.lock_owner[0]), 64'd2);
        chk("t6_cred0",  64'(dut.credits[0]), 64'd5);
        set_flit(int'(PORT_YP), 0, 1'b0, 1'b0, 64'h604);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_o_valid", 64'(o_valid), 64'd0);
        chk("t6_rst_o_ready", 64'(o_ready), 64'd0);
        clr(int'(PORT_YP));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t6_lock0_free", 64'(dut.lock_st[0]), 64'(VC_FREE));
        chk("t6_cred0_8",    64'(dut.credits[0]), 64'd8);
        set_flit(int'(PORT_YP), 0, 1'b1, 1'b1, 64'h6ff);
        cycle(5'b00100);
        clr(int'(PORT_YP));
        cycle(5'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
